// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;
    typedef enum logic {IDLE, XMIT} tx_state_t;

    localparam logic START_BIT        = 1'b0;
    localparam logic STOP_BIT         = 1'b1;
    localparam int   FRAME_BITS       = 10;
    localparam int   DEFAULT_BAUD_DIV = 2604;
endpackage

// File: rtl/uart_tx_buffered_if.sv
// Producer-side bus of the buffered UART transmitter: write port plus FIFO status.
interface uart_tx_buffered_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;

    modport master (output wr_en, wr_data, clr_ovf, input full, empty, level, overflow);
    modport slave  (input wr_en, wr_data, clr_ovf, output full, empty, level, overflow);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with show-ahead head; full/empty derived from an occupancy counter.
module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] cnt;
    logic          push, pop;

    // full gates the write even when a pop frees a slot on the same edge
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (cnt == LW'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter: FIFO drained back-to-back by a two-state serializer.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_buffered_if.slave        bus,
    output logic                     TX,
    output logic                     tx_busy,
    output logic                     tx_done
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

    tx_state_t     state, state_nxt;
    logic [9:0]    shift_reg, shift_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic          done_nxt;
    logic          pop;
    logic [7:0]    head;
    logic          fifo_full, fifo_empty;
    logic          overflow_q;

    uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (bus.level)
    );

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = overflow_q;

    // Shift register idles at all ones, so TX is always a flop output
    assign TX      = shift_reg[0];
    assign tx_busy = (state == XMIT);

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = {STOP_BIT, head, START_BIT};
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = XMIT;
                end
            end
            XMIT: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b1, shift_reg[9:1]};
                    bit_nxt   = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            tx_done   <= done_nxt;
        end
    end

    // A dropped write sets the flag even if clr_ovf arrives on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        overflow_q <= 1'b0;
        else if (bus.wr_en && fifo_full)   overflow_q <= 1'b1;
        else if (bus.clr_ovf)              overflow_q <= 1'b0;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: accepted bytes are queued; a line monitor decodes TX mid-bit and compares.
module tb_uart_tx_buffered;
    localparam int BAUD  = 16;
    localparam int DEPTH = 8;

    logic clk, rst_n, tx, tx_busy, tx_done;
    int   checks = 0, errors = 0;
    logic mon_en = 1'b0;
    logic track_full = 1'b0, full_seen = 1'b0;
    logic [7:0] sb [$];
    logic [7:0] mon_d;
    logic       mon_pend;

    uart_tx_buffered_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_buffered #(.BAUD_DIV(BAUD), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .TX      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge
    task automatic wr(input logic [7:0] b, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (accept) sb.push_back(b);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(bus.empty && !tx_busy && sb.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(n < 5000), 1);
        repeat (20) @(negedge clk);
    endtask

    // Line monitor: decode each frame at bit centres
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (7) @(negedge clk);
                check("start_bit", 32'(tx), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    mon_d[i] = tx;
                end
                repeat (BAUD) @(negedge clk);
                check("stop_bit", 32'(tx), 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %0h expected none", mon_d);
                end else begin
                    check("frame_data", 32'(mon_d), 32'(sb.pop_front()));
                end
            end
        end
    end

    // tx_done is one cycle; if more bytes are pending the next start bit follows at once
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx_done === 1'b1) begin
                mon_pend = (sb.size() > 0);
                @(negedge clk);
                check("done_width", 32'(tx_done), 0);
                if (mon_pend) check("b2b_start", 32'(tx), 0);
            end
        end
    end

    always @(negedge clk) if (track_full && bus.full) full_seen <= 1'b1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_ovf", 32'(bus.overflow), 0);

        // Reset in the middle of d4 of 8'hA5 (d4 = 0)
        rst_n = 1'b1;
        @(negedge clk);
        wr(8'hA5, 0);
        repeat (89) @(negedge clk);
        check("midframe_tx_low", 32'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 1);
        check("midrst_empty", 32'(bus.empty), 1);
        check("midrst_level", 32'(bus.level), 0);
        check("midrst_busy", 32'(tx_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) n++;
        end
        check("post_rst_quiet", 32'(n), 0);
        mon_en = 1'b1;

        // Single byte with latency and frame length
        wr(8'h6A, 1);
        check("single_empty", 32'(bus.empty), 0);
        check("single_level", 32'(bus.level), 1);
        check("single_tx_idle", 32'(tx), 1);
        @(negedge clk);
        check("single_tx_fall", 32'(tx), 0);
        check("single_busy", 32'(tx_busy), 1);
        check("single_popped", 32'(bus.empty), 1);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (tx_done === 1'b1) break;
        end
        check("frame_len", 32'(n), 160);
        wait_drain();

        // Burst of DEPTH behind a frame in flight, then overflow handling
        wr(8'h00, 1);
        repeat (2) @(negedge clk);
        for (int b = 1; b <= 8; b++) wr(8'(b), 1);
        check("burst_full", 32'(bus.full), 1);
        check("burst_level", 32'(bus.level), 8);
        wr(8'hFF, 0);
        check("ovf_set", 32'(bus.overflow), 1);
        check("ovf_level", 32'(bus.level), 8);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        check("ovf_clr", 32'(bus.overflow), 0);
        bus.clr_ovf = 1'b1;
        wr(8'hFF, 0);
        bus.clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(bus.overflow), 1);
        n = 0;
        while (bus.full && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("full_release_lvl", 32'(bus.level), 7);
        check("full_release_busy", 32'(tx_busy), 1);
        n = 0;
        while (!bus.empty && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("last_pop_busy", 32'(tx_busy), 1);
        wait_drain();

        // Write on the pop edge with level 3
        wr(8'h40, 1);
        repeat (2) @(negedge clk);
        wr(8'h41, 1);
        wr(8'h42, 1);
        wr(8'h43, 1);
        check("simul_pre_level", 32'(bus.level), 3);
        n = 0;
        while (tx_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("simul_idle", 32'(tx_busy), 0);
        check("simul_idle_level", 32'(bus.level), 3);
        wr(8'h44, 1);
        check("simul_level", 32'(bus.level), 3);
        check("simul_busy", 32'(tx_busy), 1);
        wait_drain();

        // Stream 20 bytes through the wrapping pointers without filling up
        track_full = 1'b1;
        for (int b = 8'h10; b <= 8'h23; b++) begin
            n = 0;
            while (bus.level >= 4 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            wr(8'(b), 1);
        end
        wait_drain();
        track_full = 1'b0;
        check("wrap_never_full", 32'(full_seen), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
